// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Bursts are capped at MAX_BURST words and writes never target a full FIFO.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [CNT_W-1:0]            fifo_count,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [OW-1:0]   last_owner;
  logic [BW-1:0]   burst_cnt;
  logic [CNT_W:0]  occupancy;
  logic            space;
  logic            xfer;
  logic            burst_last;
  logic [OW-1:0]   grant;
  logic            found;
  int              idx;
  logic [DATA_W-1:0] sel_data;

  // The write issued last cycle is not yet reflected in fifo_count.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_wr_en};
  assign space      = occupancy < (CNT_W+1)'(DEPTH);
  assign busy       = (state == BUSY);
  assign xfer       = busy && req[owner] && space;
  assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));

  always_comb begin
    ack = '0;
    if (xfer) ack[owner] = 1'b1;
  end

  // Search starts just after the previous owner, wrapping around.
  always_comb begin
    grant = last_owner;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant = OW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OW'(i) == owner) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_owner   <= OW'(NUM_REQ - 1);
      owner        <= OW'(NUM_REQ - 1);
      burst_cnt    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          fifo_wr_en <= 1'b0;
          if (|req) begin
            owner     <= grant;
            burst_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            fifo_wr_en   <= 1'b1;
            fifo_data_in <= sel_data;
            burst_cnt    <= burst_cnt + 1'b1;
            if (burst_last) begin
              last_owner <= owner;
              state      <= IDLE;
            end
          end else begin
            fifo_wr_en <= 1'b0;
            if (!req[owner]) begin
              last_owner <= owner;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with hand-derived expectations.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   fifo_count;
  logic [3:0]   ack;
  logic         fifo_wr_en;
  logic [31:0]  fifo_data_in;
  logic         busy;
  logic [1:0]   owner;

  int checks;
  int errors;
  logic [31:0] word_val [0:4];
  logic [31:0] src_val  [0:3];
  int exp_owner [0:4];

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .fifo_count(fifo_count), .ack(ack), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    fifo_count = '0;
    word_val[0] = 32'hA0A0_0001; word_val[1] = 32'hB0B0_0002;
    word_val[2] = 32'hC0C0_0003; word_val[3] = 32'hD0D0_0004;
    word_val[4] = 32'hE0E0_0005;
    src_val[0] = 32'h1111_0000; src_val[1] = 32'h2222_0001;
    src_val[2] = 32'h3333_0002; src_val[3] = 32'h4444_0003;
    exp_owner[0] = 0; exp_owner[1] = 1; exp_owner[2] = 2; exp_owner[3] = 3; exp_owner[4] = 0;
    #2;
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 3);
    check("rst_data", fifo_data_in, 0);
    cyc();
    rst = 1'b0;

    // T1: reset during BUSY with a write in flight
    req = 4'b0001;
    set_word(0, 32'h5555_AAAA);
    cyc();
    check("t1_owner", owner, 0);
    check("t1_ack", ack, 4'b0001);
    cyc();
    check("t1_wr_en", fifo_wr_en, 1);
    check("t1_data", fifo_data_in, 32'h5555_AAAA);
    rst = 1'b1;
    #1;
    check("t1_async_wr_en", fifo_wr_en, 0);
    check("t1_async_ack", ack, 0);
    check("t1_async_busy", busy, 0);
    check("t1_async_data", fifo_data_in, 0);
    rst = 1'b0;
    cyc();
    check("t1_regrant_owner", owner, 0);
    check("t1_regrant_busy", busy, 1);
    req = 4'b0000;
    #1;
    check("t1_drop_ack", ack, 0);
    cyc();
    check("t1_idle", busy, 0);

    // T2: five words from producer 2, burst cap of four
    req = 4'b0100;
    set_word(2, word_val[0]);
    check("t2_idle_ack", ack, 0);
    cyc();
    check("t2_owner", owner, 2);
    for (int w = 0; w < 4; w++) begin
      check("t2_ack", ack, 4'b0100);
      cyc();
      check("t2_wr_en", fifo_wr_en, 1);
      check("t2_data", fifo_data_in, word_val[w]);
      set_word(2, word_val[w+1]);
    end
    check("t2_bubble_busy", busy, 0);
    check("t2_bubble_ack", ack, 0);
    cyc();
    check("t2_after_bubble_wr_en", fifo_wr_en, 0);
    check("t2_e_ack", ack, 4'b0100);
    cyc();
    check("t2_e_wr_en", fifo_wr_en, 1);
    check("t2_e_data", fifo_data_in, word_val[4]);
    req = 4'b0000;
    #1;
    check("t2_drop_ack", ack, 0);
    cyc();
    check("t2_end_wr_en", fifo_wr_en, 0);
    check("t2_end_busy", busy, 0);

    // T3: all requesting, bursts rotate 0,1,2,3,0
    pulse_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = src_val[i];
    req = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      cyc();
      check("t3_owner", owner, exp_owner[g]);
      check("t3_gap_wr_en", fifo_wr_en, 0);
      for (int b = 0; b < 4; b++) begin
        check("t3_ack_onehot", ack, 32'(4'b0001 << exp_owner[g]));
        cyc();
        check("t3_data", fifo_data_in, src_val[exp_owner[g]]);
      end
      check("t3_bubble_ack", ack, 0);
    end
    req = 4'b0000;
    cyc();

    // T4: count of 7 admits one write, then in-flight write blocks
    fifo_count = 4'd7;
    req = 4'b0010;
    set_word(1, 32'h0707_0707);
    cyc();
    check("t4_owner", owner, 1);
    check("t4_ack_space", ack, 4'b0010);
    cyc();
    check("t4_wr_en", fifo_wr_en, 1);
    check("t4_inflight_ack", ack, 0);
    cyc();
    fifo_count = 4'd8;
    #1;
    check("t4_stall_busy", busy, 1);
    check("t4_stall_wr_en", fifo_wr_en, 0);
    check("t4_full_ack", ack, 0);
    fifo_count = 4'd6;
    #1;
    check("t4_resume_ack", ack, 4'b0010);
    req = 4'b0000;
    cyc();
    check("t4_end_busy", busy, 0);

    // T5: full FIFO for ten cycles
    fifo_count = 4'd8;
    req = 4'b0010;
    #1;
    cyc();
    for (int c = 0; c < 10; c++) begin
      check("t5_ack", ack, 0);
      check("t5_busy", busy, 1);
      check("t5_owner", owner, 1);
      check("t5_wr_en", fifo_wr_en, 0);
      cyc();
    end
    req = 4'b0000;
    fifo_count = 4'd0;
    cyc();
    check("t5_end_busy", busy, 0);

    // T6: early drop by owner 0 hands off to 3, then 1
    pulse_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = src_val[i];
    req = 4'b1001;
    #1;
    cyc();
    check("t6_owner0", owner, 0);
    check("t6_ack0a", ack, 4'b0001);
    cyc();
    check("t6_ack0b", ack, 4'b0001);
    cyc();
    check("t6_data0", fifo_data_in, src_val[0]);
    req = 4'b1000;
    #1;
    check("t6_drop_ack", ack, 0);
    cyc();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_ack", ack, 0);
    cyc();
    check("t6_owner3", owner, 3);
    req = 4'b1010;
    #1;
    check("t6_ack3", ack, 4'b1000);
    cyc();
    check("t6_data3", fifo_data_in, src_val[3]);
    req = 4'b0010;
    #1;
    check("t6_drop3_ack", ack, 0);
    cyc();
    cyc();
    check("t6_owner1", owner, 1);
    check("t6_ack1", ack, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
